// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - dual-FIFO lockstep comparator for reference vs DUT ALU results
module alu_result_checker #(
   parameter int DATA_WIDTH       = 64,
   parameter int DEPTH            = 8,
   parameter int COUNT_WIDTH      = 32,
   parameter int STOP_ON_MISMATCH = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clear,
   input  logic                   ref_push,
   input  logic [DATA_WIDTH-1:0]  ref_result,
   input  logic                   ref_result_valid,
   input  logic                   dut_push,
   input  logic [DATA_WIDTH-1:0]  dut_result,
   input  logic                   dut_result_valid,
   output logic                   ref_full,
   output logic                   dut_full,
   output logic                   compare_fire,
   output logic                   mismatch,
   output logic                   error,
   output logic                   overflow,
   output logic                   halted,
   output logic [COUNT_WIDTH-1:0] compare_count,
   output logic [COUNT_WIDTH-1:0] mismatch_count,
   output logic [DATA_WIDTH-1:0]  first_ref_result,
   output logic [DATA_WIDTH-1:0]  first_dut_result,
   output logic                   first_ref_valid,
   output logic                   first_dut_valid,
   output logic [COUNT_WIDTH-1:0] first_index
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW = DATA_WIDTH + 1;
   localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

   typedef enum logic {S_RUN, S_HALTED} state_t;

   state_t state;

   // Entry layout: {result_valid, result}
   logic [EW-1:0] ref_mem [DEPTH];
   logic [EW-1:0] dut_mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   logic [AW:0] ref_wr, ref_rd, dut_wr, dut_rd;

   logic ref_empty, dut_empty, ref_full_i, dut_full_i;
   logic pop_en, ref_acc, dut_acc, ref_drop, dut_drop;
   logic [EW-1:0] ref_head, dut_head;
   logic head_mm, captured;

   assign ref_empty  = (ref_wr == ref_rd);
   assign dut_empty  = (dut_wr == dut_rd);
   assign ref_full_i = (ref_wr[AW] != ref_rd[AW]) && (ref_wr[AW-1:0] == ref_rd[AW-1:0]);
   assign dut_full_i = (dut_wr[AW] != dut_rd[AW]) && (dut_wr[AW-1:0] == dut_rd[AW-1:0]);
   assign ref_full   = ref_full_i;
   assign dut_full   = dut_full_i;
   assign halted     = (state == S_HALTED);

   // Both heads leave together; clear and HALTED suppress popping
   assign pop_en = !ref_empty && !dut_empty && en && !clear && (state == S_RUN);

   // A full FIFO can still take a word when its head leaves in the same cycle
   assign ref_acc  = ref_push && !clear && (!ref_full_i || pop_en);
   assign dut_acc  = dut_push && !clear && (!dut_full_i || pop_en);
   assign ref_drop = ref_push && !clear && ref_full_i && !pop_en;
   assign dut_drop = dut_push && !clear && dut_full_i && !pop_en;

   assign ref_head = ref_mem[ref_rd[AW-1:0]];
   assign dut_head = dut_mem[dut_rd[AW-1:0]];

   // Valid flags must agree; data only matters when both flags are set
   assign head_mm = (ref_head[EW-1] != dut_head[EW-1]) ||
                    (ref_head[EW-1] && dut_head[EW-1] &&
                     (ref_head[DATA_WIDTH-1:0] != dut_head[DATA_WIDTH-1:0]));

   // Storage writes; contents are don't-care while the slot is unoccupied
   always_ff @(posedge clk) begin
      if (ref_acc) ref_mem[ref_wr[AW-1:0]] <= {ref_result_valid, ref_result};
      if (dut_acc) dut_mem[dut_wr[AW-1:0]] <= {dut_result_valid, dut_result};
   end

   // FIFO pointer bookkeeping; clear empties both queues
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ref_wr <= '0;
         ref_rd <= '0;
         dut_wr <= '0;
         dut_rd <= '0;
      end else if (clear) begin
         ref_wr <= '0;
         ref_rd <= '0;
         dut_wr <= '0;
         dut_rd <= '0;
      end else begin
         if (ref_acc) ref_wr <= ref_wr + PTR_ONE;
         if (dut_acc) dut_wr <= dut_wr + PTR_ONE;
         if (pop_en) begin
            ref_rd <= ref_rd + PTR_ONE;
            dut_rd <= dut_rd + PTR_ONE;
         end
      end
   end

   // Run/halt state, result pulses, sticky flags, counters and first-mismatch capture
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= S_RUN;
         compare_fire     <= 1'b0;
         mismatch         <= 1'b0;
         error            <= 1'b0;
         overflow         <= 1'b0;
         compare_count    <= '0;
         mismatch_count   <= '0;
         captured         <= 1'b0;
         first_ref_result <= '0;
         first_dut_result <= '0;
         first_ref_valid  <= 1'b0;
         first_dut_valid  <= 1'b0;
         first_index      <= '0;
      end else if (clear) begin
         state            <= S_RUN;
         compare_fire     <= 1'b0;
         mismatch         <= 1'b0;
         error            <= 1'b0;
         overflow         <= 1'b0;
         compare_count    <= '0;
         mismatch_count   <= '0;
         captured         <= 1'b0;
         first_ref_result <= '0;
         first_dut_result <= '0;
         first_ref_valid  <= 1'b0;
         first_dut_valid  <= 1'b0;
         first_index      <= '0;
      end else begin
         compare_fire <= pop_en;
         mismatch     <= pop_en && head_mm;
         if (ref_drop || dut_drop) begin
            overflow <= 1'b1;
            error    <= 1'b1;
         end
         if (pop_en) begin
            if (compare_count != CNT_MAX) compare_count <= compare_count + CNT_ONE;
            if (head_mm) begin
               error <= 1'b1;
               if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + CNT_ONE;
               if (!captured) begin
                  captured         <= 1'b1;
                  first_ref_result <= ref_head[DATA_WIDTH-1:0];
                  first_dut_result <= dut_head[DATA_WIDTH-1:0];
                  first_ref_valid  <= ref_head[EW-1];
                  first_dut_valid  <= dut_head[EW-1];
                  first_index      <= compare_count;
               end
               if (STOP_ON_MISMATCH != 0) state <= S_HALTED;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - directed vector bench for alu_result_checker
module tb_alu_result_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        clear;
   logic        ref_push, dut_push;
   logic [63:0] ref_result, dut_result;
   logic        ref_result_valid, dut_result_valid;

   // Instance A: DEPTH=4, free running
   logic        a_ref_full, a_dut_full, a_fire, a_mm, a_error, a_overflow, a_halted;
   logic [31:0] a_cc, a_mc, a_fidx;
   logic [63:0] a_fref, a_fdut;
   logic        a_frv, a_fdv;
   // Instance B: DEPTH=4, stop on mismatch
   logic        b_ref_full, b_dut_full, b_fire, b_mm, b_error, b_overflow, b_halted;
   logic [31:0] b_cc, b_mc, b_fidx;
   logic [63:0] b_fref, b_fdut;
   logic        b_frv, b_fdv;
   // Instance C: DEPTH=4, 4-bit counters
   logic        c_ref_full, c_dut_full, c_fire, c_mm, c_error, c_overflow, c_halted;
   logic [3:0]  c_cc, c_mc, c_fidx;
   logic [63:0] c_fref, c_fdut;
   logic        c_frv, c_fdv;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   alu_result_checker #(.DATA_WIDTH(64), .DEPTH(4), .COUNT_WIDTH(32), .STOP_ON_MISMATCH(0)) u_a (
      .clk(clk), .rst(rst), .en(en), .clear(clear),
      .ref_push(ref_push), .ref_result(ref_result), .ref_result_valid(ref_result_valid),
      .dut_push(dut_push), .dut_result(dut_result), .dut_result_valid(dut_result_valid),
      .ref_full(a_ref_full), .dut_full(a_dut_full), .compare_fire(a_fire), .mismatch(a_mm),
      .error(a_error), .overflow(a_overflow), .halted(a_halted),
      .compare_count(a_cc), .mismatch_count(a_mc),
      .first_ref_result(a_fref), .first_dut_result(a_fdut),
      .first_ref_valid(a_frv), .first_dut_valid(a_fdv), .first_index(a_fidx));

   alu_result_checker #(.DATA_WIDTH(64), .DEPTH(4), .COUNT_WIDTH(32), .STOP_ON_MISMATCH(1)) u_b (
      .clk(clk), .rst(rst), .en(en), .clear(clear),
      .ref_push(ref_push), .ref_result(ref_result), .ref_result_valid(ref_result_valid),
      .dut_push(dut_push), .dut_result(dut_result), .dut_result_valid(dut_result_valid),
      .ref_full(b_ref_full), .dut_full(b_dut_full), .compare_fire(b_fire), .mismatch(b_mm),
      .error(b_error), .overflow(b_overflow), .halted(b_halted),
      .compare_count(b_cc), .mismatch_count(b_mc),
      .first_ref_result(b_fref), .first_dut_result(b_fdut),
      .first_ref_valid(b_frv), .first_dut_valid(b_fdv), .first_index(b_fidx));

   alu_result_checker #(.DATA_WIDTH(64), .DEPTH(4), .COUNT_WIDTH(4), .STOP_ON_MISMATCH(0)) u_c (
      .clk(clk), .rst(rst), .en(en), .clear(clear),
      .ref_push(ref_push), .ref_result(ref_result), .ref_result_valid(ref_result_valid),
      .dut_push(dut_push), .dut_result(dut_result), .dut_result_valid(dut_result_valid),
      .ref_full(c_ref_full), .dut_full(c_dut_full), .compare_fire(c_fire), .mismatch(c_mm),
      .error(c_error), .overflow(c_overflow), .halted(c_halted),
      .compare_count(c_cc), .mismatch_count(c_mc),
      .first_ref_result(c_fref), .first_dut_result(c_fdut),
      .first_ref_valid(c_frv), .first_dut_valid(c_fdv), .first_index(c_fidx));

   typedef struct {
      logic        rv;
      logic [63:0] rd;
      logic        dv;
      logic [63:0] dd;
      logic        exp_mm;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rp, input logic rv, input logic [63:0] rd,
                        input logic dp, input logic dv, input logic [63:0] dd);
      ref_push = rp; ref_result_valid = rv; ref_result = rd;
      dut_push = dp; dut_result_valid = dv; dut_result = dd;
   endtask

   task automatic idle();
      ref_push = 1'b0;
      dut_push = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int fires;
      rst = 1'b0; en = 1'b0; clear = 1'b0;
      drive(0, 0, 64'h0, 0, 0, 64'h0);

      vecs[0] = '{1'b0, 64'hDEAD, 1'b0, 64'hBEEF, 1'b0};
      vecs[1] = '{1'b1, 64'h5,    1'b0, 64'h5,    1'b1};
      vecs[2] = '{1'b1, 64'hAA,   1'b1, 64'hAB,   1'b1};
      vecs[3] = '{1'b0, 64'h7,    1'b1, 64'h7,    1'b1};
      vecs[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[5] = '{1'b1, 64'h0,    1'b1, 64'h0,    1'b0};

      // reset state
      #12;
      chk("rst_ref_full", a_ref_full, 0);
      chk("rst_fire", a_fire, 0);
      chk("rst_cc", a_cc, 0);
      chk("rst_error", a_error, 0);
      chk("rst_halted", b_halted, 0);
      rst = 1'b1;
      tick();

      // table-driven match/mismatch vectors
      do_clear();
      en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(1, vecs[i].rv, vecs[i].rd, 1, vecs[i].dv, vecs[i].dd);
         tick();
         idle();
         tick();
         chk($sformatf("vec%0d_fire", i), a_fire, 1);
         chk($sformatf("vec%0d_mismatch", i), a_mm, vecs[i].exp_mm);
      end
      chk("vec_cc", a_cc, 6);
      chk("vec_mc", a_mc, 3);
      chk("vec_first_index", a_fidx, 1);
      chk("vec_first_ref_valid", a_frv, 1);
      chk("vec_first_ref_result", a_fref, 64'h5);
      chk("vec_first_dut_valid", a_fdv, 0);
      chk("vec_first_dut_result", a_fdut, 64'h5);
      chk("vec_error", a_error, 1);
      chk("vec_overflow", a_overflow, 0);

      // skew: ref pushes cycles 0-2, dut pushes 5-7, pulses in cycles 7-9
      do_clear();
      en = 1'b1;
      for (int c = 0; c < 12; c++) begin
         drive(c <= 2, 1, 64'(c + 1), (c >= 5 && c <= 7), 1, 64'(c - 4));
         tick();
         chk($sformatf("skew_fire_c%0d", c + 1), a_fire, (c >= 6 && c <= 8));
         chk($sformatf("skew_mm_c%0d", c + 1), a_mm, 0);
      end
      idle();
      chk("skew_cc", a_cc, 3);

      // overflow on a full FIFO with no pop
      do_clear();
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 64'(i), 0, 0, 64'h0);
         tick();
      end
      idle();
      chk("ovf_full_after4", a_ref_full, 1);
      chk("ovf_none_after4", a_overflow, 0);
      drive(1, 1, 64'h4, 0, 0, 64'h0);
      tick();
      idle();
      chk("ovf_after5", a_overflow, 1);
      chk("ovf_error", a_error, 1);

      // push into a full FIFO that pops the same cycle is accepted
      do_clear();
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 64'(i), i == 0, 1, 64'h0);
         tick();
      end
      idle();
      chk("fwp_ref_full", a_ref_full, 1);
      chk("fwp_dut_full", a_dut_full, 0);
      en = 1'b1;
      drive(1, 1, 64'h9, 0, 0, 64'h0);
      tick();
      idle();
      en = 1'b0;
      chk("fwp_fire", a_fire, 1);
      chk("fwp_overflow", a_overflow, 0);
      chk("fwp_still_full", a_ref_full, 1);

      // halt on first mismatch, then fill while halted
      do_clear();
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 64'(i + 1), 1, 1, (i == 0) ? 64'd100 : 64'(i + 1));
         tick();
      end
      idle();
      tick();
      tick();
      chk("halt_halted", b_halted, 1);
      chk("halt_cc", b_cc, 1);
      chk("halt_mc", b_mc, 1);
      chk("halt_first_index", b_fidx, 0);
      chk("halt_ref_full", b_ref_full, 1);
      chk("halt_dut_full", b_dut_full, 1);
      chk("halt_no_ovf_yet", b_overflow, 0);
      drive(1, 1, 64'h6, 1, 1, 64'h6);
      tick();
      idle();
      chk("halt_overflow", b_overflow, 1);
      do_clear();
      chk("halt_clr_halted", b_halted, 0);
      chk("halt_clr_cc", b_cc, 0);
      chk("halt_clr_mc", b_mc, 0);
      chk("halt_clr_full", b_ref_full, 0);
      chk("halt_clr_error", b_error, 0);

      // counter saturation with 4-bit counters
      do_clear();
      en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 64'(i), 1, 1, 64'(i) ^ 64'h1);
         tick();
      end
      idle();
      tick();
      tick();
      chk("sat_mc", c_mc, 15);
      chk("sat_cc", c_cc, 15);
      chk("sat_first_index", c_fidx, 0);
      chk("sat_first_dut", c_fdut, 64'h1);
      chk("sat_wide_cc", a_cc, 20);

      // asynchronous reset mid-stream
      do_clear();
      en = 1'b1;
      drive(1, 1, 64'h3, 1, 1, 64'h4);
      tick();
      idle();
      tick();
      chk("ar_pre_cc", a_cc, 1);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 64'(i), 1, 1, 64'(i));
         tick();
      end
      idle();
      chk("ar_pre_full", a_ref_full, 1);
      #3;
      rst = 1'b0;
      #1;
      chk("ar_ref_full", a_ref_full, 0);
      chk("ar_dut_full", a_dut_full, 0);
      chk("ar_cc", a_cc, 0);
      chk("ar_mc", a_mc, 0);
      chk("ar_error", a_error, 0);
      chk("ar_first_dut", a_fdut, 0);
      chk("ar_first_ref_valid", a_frv, 0);
      #2;
      rst = 1'b1;
      en = 1'b1;
      fires = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (a_fire || a_mm) fires++;
      end
      chk("ar_no_pulse", 64'(fires), 0);
      drive(1, 1, 64'h8, 1, 1, 64'h8);
      tick();
      idle();
      tick();
      chk("ar_post_fire", a_fire, 1);
      chk("ar_post_cc", a_cc, 1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
